// File: rtl/bp_io_cmd_mux_pkg.sv
// bp_io_cmd_mux_pkg: shared constants, channel-id type and id-width helper for the IO command mux.
package bp_io_cmd_mux_pkg;

    localparam int max_ch_lp = 8;
    localparam int ch_id_width_lp = $clog2(max_ch_lp);

    typedef logic [ch_id_width_lp-1:0] ch_id_t;

    // A single channel still needs one bit to hold its id.
    function automatic int safe_id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bp_io_cmd_mux_order_fifo.sv
// bp_io_cmd_mux_order_fifo: small FIFO of issuing channel ids; push and pop may coincide even when full.
module bp_io_cmd_mux_order_fifo #(
    parameter int els_p   = 4,
    parameter int width_p = 1
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic [width_p-1:0]           data_i,
    input  logic                         v_i,
    input  logic                         yumi_i,
    output logic [width_p-1:0]           data_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(els_p+1)-1:0]   count_o
);

    localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int cnt_w_lp = $clog2(els_p+1);

    logic [width_p-1:0]  mem_r [els_p];
    logic [ptr_w_lp-1:0] wptr_r, rptr_r;
    logic [cnt_w_lp-1:0] cnt_r;

    function automatic logic [ptr_w_lp-1:0] nxt(input logic [ptr_w_lp-1:0] p);
        return (p == ptr_w_lp'(els_p-1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr_r <= '0;
            rptr_r <= '0;
            cnt_r  <= '0;
        end else begin
            wptr_r <= v_i ? nxt(wptr_r) : wptr_r;
            rptr_r <= yumi_i ? nxt(rptr_r) : rptr_r;
            cnt_r  <= cnt_r + cnt_w_lp'(v_i) - cnt_w_lp'(yumi_i);
        end
    end

    // When full, the write slot equals the read slot; the head is read out combinationally before it is overwritten.
    always_ff @(posedge clk_i) begin
        if (v_i) mem_r[wptr_r] <= data_i;
    end

    assign data_o  = mem_r[rptr_r];
    assign full_o  = (cnt_r == cnt_w_lp'(els_p));
    assign empty_o = (cnt_r == '0);
    assign count_o = cnt_r;

endmodule

// File: rtl/bp_io_cmd_mux.sv
// bp_io_cmd_mux: round-robin merge of N IO command channels onto one core port, with in-order response routing.
// Optional per-channel statistics built when BP_IO_CMD_MUX_STATS_EN is defined.
module bp_io_cmd_mux
    import bp_io_cmd_mux_pkg::*;
#(
    parameter int num_ch_p          = 2,
    parameter int msg_width_p       = 128,
    parameter int max_outstanding_p = 4,
    parameter int stat_width_p      = 32
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic [num_ch_p*msg_width_p-1:0]   ch_cmd_i,
    input  logic [num_ch_p-1:0]               ch_cmd_v_i,
    output logic [num_ch_p-1:0]               ch_cmd_yumi_o,
    output logic [msg_width_p-1:0]            ch_resp_o,
    output logic [num_ch_p-1:0]               ch_resp_v_o,
    input  logic [num_ch_p-1:0]               ch_resp_ready_i,
    output logic [msg_width_p-1:0]            io_cmd_o,
    output logic                              io_cmd_v_o,
    input  logic                              io_cmd_ready_i,
    input  logic [msg_width_p-1:0]            io_resp_i,
    input  logic                              io_resp_v_i,
    output logic                              io_resp_yumi_o,
    output logic                              error_o
`ifdef BP_IO_CMD_MUX_STATS_EN
    ,output logic [num_ch_p*stat_width_p-1:0]        ch_cmd_count_o
    ,output logic [$clog2(max_outstanding_p+1)-1:0]  max_outstanding_seen_o
`endif
);

    localparam int id_w_lp  = safe_id_width(num_ch_p);
    localparam int cnt_w_lp = $clog2(max_outstanding_p+1);

    if (num_ch_p < 1 || num_ch_p > max_ch_lp || stat_width_p < 1) begin : g_bad_param
        $error("bp_io_cmd_mux: unsupported parameterisation");
    end

    logic [id_w_lp-1:0]  ptr_r, grant, idx, head;
    logic [cnt_w_lp-1:0] count;
    logic full, empty, cmd_hs, resp_match, head_rdy, resp_pop, err_r;

    // Scan from lowest to highest priority so the first valid channel at or after the pointer wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        for (int i = num_ch_p-1; i >= 0; i--) begin
            idx   = id_w_lp'((int'(ptr_r) + i) % num_ch_p);
            grant = ch_cmd_v_i[idx] ? idx : grant;
        end
    end

    assign resp_match     = io_resp_v_i & ~empty;
    assign head_rdy       = |(ch_resp_ready_i & (num_ch_p'(1) << head));
    assign resp_pop       = resp_match & head_rdy;
    assign io_resp_yumi_o = io_resp_v_i & (empty | head_rdy);
    assign ch_resp_v_o    = resp_match ? (num_ch_p'(1) << head) : '0;
    assign ch_resp_o      = resp_match ? io_resp_i : '0;

    // A same-cycle pop frees a slot, so a full FIFO can still accept.
    assign io_cmd_v_o    = (|ch_cmd_v_i) & (~full | resp_pop);
    assign cmd_hs        = io_cmd_v_o & io_cmd_ready_i;
    assign io_cmd_o      = ch_cmd_i[grant*msg_width_p +: msg_width_p];
    assign ch_cmd_yumi_o = cmd_hs ? (num_ch_p'(1) << grant) : '0;
    assign error_o       = err_r;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ptr_r <= '0;
            err_r <= 1'b0;
        end else begin
            ptr_r <= cmd_hs ? ((int'(grant) == num_ch_p-1) ? '0 : grant + 1'b1) : ptr_r;
            err_r <= err_r | (io_resp_v_i & empty);
        end
    end

    bp_io_cmd_mux_order_fifo #(
        .els_p   (max_outstanding_p),
        .width_p (id_w_lp)
    ) order_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .data_i  (grant),
        .v_i     (cmd_hs),
        .yumi_i  (resp_pop),
        .data_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

`ifdef BP_IO_CMD_MUX_STATS_EN
    logic [cnt_w_lp-1:0] seen_r;

    for (genvar c = 0; c < num_ch_p; c++) begin : g_cnt
        logic [stat_width_p-1:0] cnt_r;
        always_ff @(posedge clk_i) begin
            if (reset_i) cnt_r <= '0;
            else if (ch_cmd_yumi_o[c] && !(&cnt_r)) cnt_r <= cnt_r + 1'b1;
        end
        assign ch_cmd_count_o[c*stat_width_p +: stat_width_p] = cnt_r;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) seen_r <= '0;
        else seen_r <= (count > seen_r) ? count : seen_r;
    end

    assign max_outstanding_seen_o = seen_r;
`else
    logic unused_count;
    assign unused_count = ^count;
`endif

endmodule

// File: tb/tb_bp_io_cmd_mux.sv
// tb_bp_io_cmd_mux: table-driven directed checks of arbitration, order tracking and response routing.
module tb_bp_io_cmd_mux;

    logic         clk = 1'b0;
    logic         reset_i;
    logic [255:0] ch_cmd_i;
    logic [1:0]   ch_cmd_v_i, ch_cmd_yumi_o, ch_resp_v_o, ch_resp_ready_i;
    logic [127:0] ch_resp_o, io_cmd_o, io_resp_i;
    logic         io_cmd_v_o, io_cmd_ready_i, io_resp_v_i, io_resp_yumi_o, error_o;
`ifdef BP_IO_CMD_MUX_STATS_EN
    logic [63:0]  ch_cmd_count_o;
    logic [2:0]   max_outstanding_seen_o;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bp_io_cmd_mux dut (
        .clk_i           (clk),
        .reset_i         (reset_i),
        .ch_cmd_i        (ch_cmd_i),
        .ch_cmd_v_i      (ch_cmd_v_i),
        .ch_cmd_yumi_o   (ch_cmd_yumi_o),
        .ch_resp_o       (ch_resp_o),
        .ch_resp_v_o     (ch_resp_v_o),
        .ch_resp_ready_i (ch_resp_ready_i),
        .io_cmd_o        (io_cmd_o),
        .io_cmd_v_o      (io_cmd_v_o),
        .io_cmd_ready_i  (io_cmd_ready_i),
        .io_resp_i       (io_resp_i),
        .io_resp_v_i     (io_resp_v_i),
        .io_resp_yumi_o  (io_resp_yumi_o),
        .error_o         (error_o)
`ifdef BP_IO_CMD_MUX_STATS_EN
        ,.ch_cmd_count_o         (ch_cmd_count_o)
        ,.max_outstanding_seen_o (max_outstanding_seen_o)
`endif
    );

    typedef struct {
        logic [1:0]  v;
        logic [15:0] c0, c1;
        logic        rdy, rv;
        logic [15:0] rd;
        logic [1:0]  rr;
        logic [1:0]  e_yumi;
        logic        e_cv;
        logic [15:0] e_cmd;
        logic [1:0]  e_rv;
        logic [15:0] e_rdata;
        logic        e_ryumi, e_err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic [1:0] v, logic [15:0] c0, logic [15:0] c1, logic rdy, logic rv,
                                logic [15:0] rd, logic [1:0] rr, logic [1:0] e_yumi, logic e_cv,
                                logic [15:0] e_cmd, logic [1:0] e_rv, logic [15:0] e_rdata,
                                logic e_ryumi, logic e_err);
        vec_t t;
        t.v = v; t.c0 = c0; t.c1 = c1; t.rdy = rdy; t.rv = rv; t.rd = rd; t.rr = rr;
        t.e_yumi = e_yumi; t.e_cv = e_cv; t.e_cmd = e_cmd; t.e_rv = e_rv;
        t.e_rdata = e_rdata; t.e_ryumi = e_ryumi; t.e_err = e_err;
        return t;
    endfunction

    task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic drive(logic [1:0] v, logic [15:0] c0, logic [15:0] c1, logic rdy, logic rv,
                         logic [15:0] rd, logic [1:0] rr);
        ch_cmd_v_i      = v;
        ch_cmd_i        = {112'b0, c1, 112'b0, c0};
        io_cmd_ready_i  = rdy;
        io_resp_v_i     = rv;
        io_resp_i       = {112'b0, rd};
        ch_resp_ready_i = rr;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_i = 1'b1;
        drive(2'b00, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 2'b00);
        @(negedge clk);
        reset_i = 1'b0;
    endtask

    initial begin
        reset_i = 1'b1;
        drive(2'b00, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 2'b00);
        repeat (2) @(negedge clk);
        #1;
        chk("rst_cmd_v", 128'(io_cmd_v_o), 128'd0);
        chk("rst_cmd_yumi", 128'(ch_cmd_yumi_o), 128'd0);
        chk("rst_resp_v", 128'(ch_resp_v_o), 128'd0);
        chk("rst_resp_yumi", 128'(io_resp_yumi_o), 128'd0);
        chk("rst_resp_data", ch_resp_o, 128'd0);
        chk("rst_err", 128'(error_o), 128'd0);
        reset_i = 1'b0;

        // single channel 1 issuing three commands, then three responses
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(2'b10, 16'h0, 16'h11 + 16'(i), 1, 0, 16'h0, 2'b11, 2'b10, 1, 16'h11 + 16'(i), 2'b00, 16'h0, 0, 0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(2'b00, 16'h0, 16'h0, 1, 1, 16'h51 + 16'(i), 2'b11, 2'b00, 0, 16'h0, 2'b10, 16'h51 + 16'(i), 1, 0));
        // both channels contending, responses one cycle behind
        tbl.push_back(mk(2'b11, 16'h20, 16'h21, 1, 0, 16'h0,  2'b11, 2'b01, 1, 16'h20, 2'b00, 16'h0,  0, 0));
        tbl.push_back(mk(2'b11, 16'h22, 16'h23, 1, 1, 16'h60, 2'b11, 2'b10, 1, 16'h23, 2'b01, 16'h60, 1, 0));
        tbl.push_back(mk(2'b11, 16'h24, 16'h25, 1, 1, 16'h61, 2'b11, 2'b01, 1, 16'h24, 2'b10, 16'h61, 1, 0));
        tbl.push_back(mk(2'b11, 16'h26, 16'h27, 1, 1, 16'h62, 2'b11, 2'b10, 1, 16'h27, 2'b01, 16'h62, 1, 0));
        tbl.push_back(mk(2'b00, 16'h0,  16'h0,  1, 1, 16'h63, 2'b11, 2'b00, 0, 16'h0,  2'b10, 16'h63, 1, 0));
        // fill to four outstanding, then blocked, then accepted alongside a pop
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(2'b01, 16'h30 + 16'(i), 16'h0, 1, 0, 16'h0, 2'b11, 2'b01, 1, 16'h30 + 16'(i), 2'b00, 16'h0, 0, 0));
        tbl.push_back(mk(2'b01, 16'h34, 16'h0,  1, 0, 16'h0,  2'b11, 2'b00, 0, 16'h0,  2'b00, 16'h0,  0, 0));
        tbl.push_back(mk(2'b10, 16'h0,  16'h35, 1, 1, 16'h70, 2'b11, 2'b10, 1, 16'h35, 2'b01, 16'h70, 1, 0));
        // head channel 0 not ready for five cycles
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(2'b00, 16'h0, 16'h0, 1, 1, 16'h80, 2'b10, 2'b00, 0, 16'h0, 2'b01, 16'h80, 0, 0));
        tbl.push_back(mk(2'b00, 16'h0, 16'h0, 1, 1, 16'h80, 2'b11, 2'b00, 0, 16'h0, 2'b01, 16'h80, 1, 0));
        tbl.push_back(mk(2'b00, 16'h0, 16'h0, 1, 1, 16'h81, 2'b11, 2'b00, 0, 16'h0, 2'b01, 16'h81, 1, 0));
        tbl.push_back(mk(2'b00, 16'h0, 16'h0, 1, 1, 16'h81, 2'b11, 2'b00, 0, 16'h0, 2'b01, 16'h81, 1, 0));
        tbl.push_back(mk(2'b00, 16'h0, 16'h0, 1, 1, 16'h82, 2'b11, 2'b00, 0, 16'h0, 2'b10, 16'h82, 1, 0));
        // core not ready: valid offered, nothing consumed
        tbl.push_back(mk(2'b11, 16'h40, 16'h41, 0, 0, 16'h0, 2'b11, 2'b00, 1, 16'h40, 2'b00, 16'h0, 0, 0));
        tbl.push_back(mk(2'b11, 16'h40, 16'h41, 1, 0, 16'h0, 2'b11, 2'b01, 1, 16'h40, 2'b00, 16'h0, 0, 0));

        foreach (tbl[n]) begin
            @(negedge clk);
            drive(tbl[n].v, tbl[n].c0, tbl[n].c1, tbl[n].rdy, tbl[n].rv, tbl[n].rd, tbl[n].rr);
            #1;
            chk($sformatf("v%0d_cmd_yumi", n), 128'(ch_cmd_yumi_o), 128'(tbl[n].e_yumi));
            chk($sformatf("v%0d_cmd_v", n), 128'(io_cmd_v_o), 128'(tbl[n].e_cv));
            if (tbl[n].e_cv) chk($sformatf("v%0d_cmd", n), io_cmd_o, 128'(tbl[n].e_cmd));
            chk($sformatf("v%0d_resp_v", n), 128'(ch_resp_v_o), 128'(tbl[n].e_rv));
            if (tbl[n].e_rv != 2'b00) chk($sformatf("v%0d_resp_data", n), ch_resp_o, 128'(tbl[n].e_rdata));
            chk($sformatf("v%0d_resp_yumi", n), 128'(io_resp_yumi_o), 128'(tbl[n].e_ryumi));
            chk($sformatf("v%0d_err", n), 128'(error_o), 128'(tbl[n].e_err));
        end

        // unmatched response straight after reset
        do_reset();
        drive(2'b00, 16'h0, 16'h0, 1'b0, 1'b1, 16'h90, 2'b00);
        #1;
        chk("unm_resp_yumi", 128'(io_resp_yumi_o), 128'd1);
        chk("unm_resp_v", 128'(ch_resp_v_o), 128'd0);
        chk("unm_err_same_cycle", 128'(error_o), 128'd0);
        @(negedge clk);
        drive(2'b00, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 2'b00);
        #1;
        chk("unm_err_set", 128'(error_o), 128'd1);
        @(negedge clk);
        #1;
        chk("unm_err_held", 128'(error_o), 128'd1);

        // reset with two commands in flight
        do_reset();
        #1;
        chk("mid_err_clear", 128'(error_o), 128'd0);
        drive(2'b01, 16'hA0, 16'h0, 1'b1, 1'b0, 16'h0, 2'b11);
        #1;
        chk("mid_cmd0_yumi", 128'(ch_cmd_yumi_o), 128'd1);
        @(negedge clk);
        drive(2'b01, 16'hA1, 16'h0, 1'b1, 1'b0, 16'h0, 2'b11);
        #1;
        chk("mid_cmd1_yumi", 128'(ch_cmd_yumi_o), 128'd1);
        do_reset();
        #1;
`ifdef BP_IO_CMD_MUX_STATS_EN
        chk("stat_cnt_reset", 128'(ch_cmd_count_o), 128'd0);
        chk("stat_seen_reset", 128'(max_outstanding_seen_o), 128'd0);
`endif
        drive(2'b00, 16'h0, 16'h0, 1'b1, 1'b1, 16'hB0, 2'b11);
        #1;
        chk("mid_resp0_yumi", 128'(io_resp_yumi_o), 128'd1);
        chk("mid_resp0_v", 128'(ch_resp_v_o), 128'd0);
        chk("mid_resp0_err", 128'(error_o), 128'd0);
        @(negedge clk);
        drive(2'b00, 16'h0, 16'h0, 1'b1, 1'b1, 16'hB1, 2'b11);
        #1;
        chk("mid_resp1_yumi", 128'(io_resp_yumi_o), 128'd1);
        chk("mid_resp1_v", 128'(ch_resp_v_o), 128'd0);
        chk("mid_resp1_err", 128'(error_o), 128'd1);
        @(negedge clk);
        drive(2'b10, 16'h0, 16'hC0, 1'b1, 1'b0, 16'h0, 2'b11);
        #1;
        chk("post_cmd_yumi", 128'(ch_cmd_yumi_o), 128'd2);
        chk("post_err_held", 128'(error_o), 128'd1);
        @(negedge clk);
        drive(2'b00, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 2'b00);
        #1;
`ifdef BP_IO_CMD_MUX_STATS_EN
        chk("stat_cnt_ch0", 128'(ch_cmd_count_o[31:0]), 128'd0);
        chk("stat_cnt_ch1", 128'(ch_cmd_count_o[63:32]), 128'd1);
`endif
        chk("post_idle_cmd_v", 128'(io_cmd_v_o), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bp_io_cmd_mux.md
Name: bp_io_cmd_mux

Overview:
- N-channel IO command merger for BlackParrot single-core test harnesses.
- Arbitrates N host-side IO command sources (NBF loader, host MMIO, future DMA) onto one core `io_cmd_i` port.
- Routes in-order IO responses back to the channel that issued each command.
- Generalises the fixed single-loader hookup to a parametrised channel count, with outstanding-command tracking.

Parameters:
- num_ch_p, 2, number of command source channels (1..8).
- msg_width_p, 128, width of one packed bedrock mem message (header+data).
- max_outstanding_p, 4, maximum commands in flight awaiting response (power of 2, ≥1).
- stat_width_p, 32, width of per-channel statistics counters (used only with the optional feature).

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous active-high reset.
- ch_cmd_i  in  num_ch_p*msg_width_p  per-channel command messages.
- ch_cmd_v_i  in  num_ch_p  per-channel command valid.
- ch_cmd_yumi_o  out  num_ch_p  per-channel command consumed.
- ch_resp_o  out  msg_width_p  response message, shared by all channels.
- ch_resp_v_o  out  num_ch_p  per-channel response valid (one-hot or zero).
- ch_resp_ready_i  in  num_ch_p  per-channel response ready.
- io_cmd_o  out  msg_width_p  merged command to the core.
- io_cmd_v_o  out  1  merged command valid.
- io_cmd_ready_i  in  1  core ready for a command.
- io_resp_i  in  msg_width_p  response from the core.
- io_resp_v_i  in  1  response valid.
- io_resp_yumi_o  out  1  response consumed.
- error_o  out  1  sticky: a response arrived with no command outstanding.

Behaviour:
- Single clock domain on clk_i; reset_i is synchronous and active-high.
- Reset values:
  - All outputs 0.
  - Round-robin pointer = channel 0.
  - Order FIFO empty; outstanding count 0; error_o 0.
- Command path is combinational (0-cycle latency):
  - io_cmd_v_o = (any ch_cmd_v_i) & !fifo_full.
  - io_cmd_o = message of the granted channel.
- Arbitration is round-robin:
  - Grant goes to the first valid channel at or after the pointer, wrapping.
  - On handshake (io_cmd_v_o & io_cmd_ready_i):
    - ch_cmd_yumi_o[grant] = 1.
    - Grant id is pushed into the order FIFO.
    - Pointer moves to grant+1 mod num_ch_p.
  - Pointer holds when no handshake occurs.
  - Grant is stable within a cycle. It may change between cycles while io_cmd_ready_i is low; sources are helpful producers and must not retract valid.
- Order FIFO:
  - Depth max_outstanding_p, width clog2(num_ch_p) (min 1).
  - Full at max_outstanding_p entries → io_cmd_v_o = 0 and no yumi.
- Response path:
  - When io_resp_v_i & FIFO non-empty: ch_resp_v_o[head] = 1 and ch_resp_o = io_resp_i.
  - io_resp_yumi_o = ch_resp_ready_i[head]; the FIFO pops on yumi.
  - Other channels see v = 0.
- Simultaneous push and pop in one cycle is legal at any occupancy, including full (pop frees a slot the same cycle), so io_cmd_v_o also considers a same-cycle pop.
- Unmatched response (io_resp_v_i with FIFO empty):
  - io_resp_yumi_o = 1 (drained), no ch_resp_v_o asserted.
  - error_o set and held until reset.
- Reset mid-operation clears FIFO and pointer. Responses to pre-reset commands are then unmatched and raise error_o.
- num_ch_p = 1: the arbiter degenerates to pass-through and the FIFO only counts outstanding commands.

Optional Feature:
- Macro BP_IO_CMD_MUX_STATS_EN.
- Defined:
  - Adds output ch_cmd_count_o, num_ch_p*stat_width_p.
  - Per-channel counter of accepted commands, +1 on each ch_cmd_yumi_o, saturating at all-ones, reset to 0.
  - Adds output max_outstanding_seen_o, clog2(max_outstanding_p+1), the high-water mark of FIFO occupancy.
- Undefined: neither port exists and no counter logic is built.

Decomposition:
- Package bp_io_cmd_mux_pkg holds:
  - max channel-count constant (8).
  - channel-id typedef.
  - helper function for the safe channel-id width.
- Arbitration uses the existing bsg_arb_round_robin.
- One natural sub-module: bp_io_cmd_mux_order_fifo. It wraps a bsg_fifo_1r1w_small of channel ids, exports full/empty/count, and permits push+pop when full.

Test Plan:
1. num_ch_p=2, only ch1 valid with 3 cmds, io_cmd_ready_i=1 → 3 yumis on ch1 in 3 cycles; FIFO holds {1,1,1}; 3 responses routed to ch1 only.
2. Both channels valid continuously, ready always 1, responses returned 1 cycle later → grants alternate 0,1,0,1; each channel receives exactly its own responses in order.
3. max_outstanding_p=4, no responses → after 4 accepted cmds io_cmd_v_o=0; one response popped in the same cycle a new cmd is offered → that cmd is accepted that cycle.
4. Response head = ch0 while ch_resp_ready_i[0]=0 for 5 cycles → io_resp_yumi_o=0 for 5 cycles; ch1 sees no valid; pop occurs when ready rises.
5. io_resp_v_i=1 after reset with no commands issued → io_resp_yumi_o=1, ch_resp_v_o=0, error_o=1 from the next cycle, held.
6. Reset asserted with 2 outstanding; two responses then arrive → both drained and error_o=1. With BP_IO_CMD_MUX_STATS_EN, counters read 0 after reset and increment correctly afterwards.
